// File: rtl/skew_delay_array.sv
// skew_delay_array
//   Multi-lane delay line that applies a lane-dependent latency. With
//   REVERSE=0, lane i is delayed by BASE+STEP*i cycles. This produces the
//   diagonal skew that a systolic array expects on its row/column inputs.
//   With REVERSE=1, lane i is delayed by BASE+STEP*(LANES-1-i). This removes
//   that skew again on the array outputs.
//   Every stage carries a valid bit next to its data word. Invalid slots
//   always hold zero data, so the array sees zero padding.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears every stage
//   en         advance enable, 0 freezes every stage
//   flush      synchronous clear of every stage, wins over en
//   in_valid   per-lane input qualifier               [LANES]
//   in_data    per-lane input word, lane i at [i*WIDTH +: WIDTH]
//   out_valid  per-lane delayed qualifier             [LANES]
//   out_data   per-lane delayed word, zero when its out_valid is 0
//   busy       1 while any valid bit is stored in any registered lane
module skew_delay_array #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int BASE    = 0,
  parameter int STEP    = 1,
  parameter int REVERSE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy
);

  logic [LANES-1:0] lane_busy;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int K = (REVERSE != 0) ? (LANES - 1 - i) : i;
    localparam int D = BASE + STEP * K;

    if (D == 0) begin : g_pass
      // A zero-delay lane is pure wiring.
      // Reset, flush and en have no effect on it.
      assign out_valid[i]                = in_valid[i];
      assign out_data[i*WIDTH +: WIDTH]  = in_valid[i] ? in_data[i*WIDTH +: WIDTH] : '0;
      assign lane_busy[i]                = 1'b0;
    end else begin : g_pipe
      logic [D-1:0]     valid_q;
      logic [D-1:0]     valid_d;
      logic [WIDTH-1:0] data_q [D];
      logic [WIDTH-1:0] data_d [D];

      // Stage D-1 takes the input and stage 0 drives the output.
      // Flush beats en. A slot captured without valid stores zero data,
      // so stale words never leak into the padding.
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
          valid_d = '0;
          for (int k = 0; k < D; k++) begin
            data_d[k] = '0;
          end
        end else if (en) begin
          for (int k = 0; k < D - 1; k++) begin
            valid_d[k] = valid_q[k+1];
            data_d[k]  = data_q[k+1];
          end
          valid_d[D-1] = in_valid[i];
          data_d[D-1]  = in_valid[i] ? in_data[i*WIDTH +: WIDTH] : '0;
        end
      end

      // Stage registers.
      // Reset clears them immediately, without waiting for a clock edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          for (int k = 0; k < D; k++) begin
            data_q[k] <= '0;
          end
        end else begin
          valid_q <= valid_d;
          for (int k = 0; k < D; k++) begin
            data_q[k] <= data_d[k];
          end
        end
      end

      assign out_valid[i]               = valid_q[0];
      assign out_data[i*WIDTH +: WIDTH] = data_q[0] & {WIDTH{valid_q[0]}};
      assign lane_busy[i]               = |valid_q;
    end
  end

  assign busy = |lane_busy;

endmodule

// File: tb/tb_skew_delay_array.sv
// tb_skew_delay_array
//   Drives three instances of skew_delay_array from shared clk/rst/en/flush:
//     uA: LANES=4 BASE=1 STEP=1 REVERSE=0 (skew, delays 1..4)
//     uB: LANES=4 BASE=1 STEP=1 REVERSE=1, fed from uA (de-skew, delays 4..1)
//     uC: LANES=3 BASE=0 STEP=2 (delays 0,2,4, lane 0 combinational)
//   The reference model tracks time in enabled edges and does not model
//   shift registers. Each enabled edge gets an index, and every lane's
//   captured word is logged under that index. A flush or reset sets a
//   clear mark, and any entry at or below the mark no longer exists.
//   The output of a lane with delay D is the entry captured D-1 indices ago.
module tb_skew_delay_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  aIv = '0;
  logic [31:0] aId = '0;
  logic [2:0]  cIv = '0;
  logic [23:0] cId = '0;
  logic [3:0]  aOv, bOv;
  logic [31:0] aOd, bOd;
  logic [2:0]  cOv;
  logic [23:0] cOd;
  logic        aBusy, bBusy, cBusy;

  int total = 0;
  int bad = 0;

  // Model state: index of the last enabled edge and the clear mark.
  int cnt = 0;
  int clr = 0;
  bit         capV [3][4][64];
  logic [7:0] capD [3][4][64];
  bit         mBv [4];
  logic [7:0] mBd [4];

  always #5 clk = ~clk;

  skew_delay_array #(.WIDTH(8), .LANES(4), .BASE(1), .STEP(1), .REVERSE(0)) uA (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(aIv), .in_data(aId), .out_valid(aOv), .out_data(aOd), .busy(aBusy));

  skew_delay_array #(.WIDTH(8), .LANES(4), .BASE(1), .STEP(1), .REVERSE(1)) uB (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(aOv), .in_data(aOd), .out_valid(bOv), .out_data(bOd), .busy(bBusy));

  skew_delay_array #(.WIDTH(8), .LANES(3), .BASE(0), .STEP(2), .REVERSE(0)) uC (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(cIv), .in_data(cId), .out_valid(cOv), .out_data(cOd), .busy(cBusy));

  function automatic int dOf(input int inst, input int lane);
    case (inst)
      0:       return 1 + lane;
      1:       return 1 + (3 - lane);
      default: return 2 * lane;
    endcase
  endfunction

  function automatic int lanesOf(input int inst);
    return (inst == 2) ? 3 : 4;
  endfunction

  // Expected output of one lane, derived from the capture log.
  function automatic void expLane(input int inst, input int lane,
                                  output bit v, output logic [7:0] d);
    int dl;
    int idx;
    dl = dOf(inst, lane);
    v = 1'b0;
    d = 8'h00;
    if (dl == 0) begin
      v = cIv[lane];
      d = v ? cId[8*lane +: 8] : 8'h00;
    end else if (!rst) begin
      idx = cnt - dl + 1;
      if (idx > clr) begin
        v = capV[inst][lane][idx % 64];
        d = v ? capD[inst][lane][idx % 64] : 8'h00;
      end
    end
  endfunction

  // Busy is expected when any word that has not been cleared is still
  // inside its lane's delay window.
  function automatic bit expBusy(input int inst);
    int dl;
    int idx;
    bit b;
    b = 1'b0;
    for (int l = 0; l < lanesOf(inst); l++) begin
      dl = dOf(inst, l);
      for (int j = 0; j < dl; j++) begin
        idx = cnt - j;
        if (!rst && idx > clr) begin
          if (capV[inst][l][idx % 64]) b = 1'b1;
        end
      end
    end
    return b;
  endfunction

  // Model update.
  // uB's input is the expected output of uA just before the edge.
  initial begin
    int n;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        clr = cnt;
      end else if (flush) begin
        clr = cnt;
      end else if (en) begin
        for (int l = 0; l < 4; l++) expLane(0, l, mBv[l], mBd[l]);
        n = (cnt + 1) % 64;
        for (int l = 0; l < 4; l++) begin
          capV[0][l][n] = aIv[l];
          capD[0][l][n] = aId[8*l +: 8];
          capV[1][l][n] = mBv[l];
          capD[1][l][n] = mBd[l];
        end
        for (int l = 0; l < 3; l++) begin
          capV[2][l][n] = cIv[l];
          capD[2][l][n] = cId[8*l +: 8];
        end
        cnt = cnt + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Set the inputs, let one clock edge pass, then return 2 time units after
  // that edge, when the outputs have settled.
  task automatic applyStimulus(input logic [3:0] av, input logic [31:0] ad,
                               input logic [2:0] cv, input logic [23:0] cd,
                               input bit e, input bit f);
    aIv = av; aId = ad; cIv = cv; cId = cd; en = e; flush = f;
    @(posedge clk);
    #2;
  endtask

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    bit v;
    logic [7:0] d;
    logic       av;
    logic [7:0] ad;
    for (int inst = 0; inst < 3; inst++) begin
      for (int l = 0; l < lanesOf(inst); l++) begin
        expLane(inst, l, v, d);
        case (inst)
          0:       begin av = aOv[l]; ad = aOd[8*l +: 8]; end
          1:       begin av = bOv[l]; ad = bOd[8*l +: 8]; end
          default: begin av = cOv[l]; ad = cOd[8*l +: 8]; end
        endcase
        checkOutput($sformatf("model_valid_i%0d_l%0d", inst, l), 32'(av), 32'(v));
        checkOutput($sformatf("model_data_i%0d_l%0d", inst, l), 32'(ad), 32'(d));
      end
    end
    checkOutput("model_busyA", 32'(aBusy), 32'(expBusy(0)));
    checkOutput("model_busyB", 32'(bBusy), 32'(expBusy(1)));
    checkOutput("model_busyC", 32'(cBusy), 32'(expBusy(2)));
  end

  initial begin
    logic [7:0] seen [$];
    logic [31:0] expD;

    // Reset state.
    #1;
    checkOutput("reset_validA", 32'(aOv), 32'h0);
    checkOutput("reset_busyA", 32'(aBusy), 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // Single pulse on all lanes of uA produces the diagonal skew.
    applyStimulus(4'hF, 32'h44332211, 3'h0, 24'h0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      expD = (32'h11 * 32'(k)) << (8 * (k - 1));
      checkOutput($sformatf("pulse_valid_%0d", k), 32'(aOv), 32'h1 << (k - 1));
      checkOutput($sformatf("pulse_data_%0d", k), aOd, expD);
      checkOutput($sformatf("pulse_busy_%0d", k), 32'(aBusy), 32'h1);
      applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);
    end
    checkOutput("pulse_end_validA", 32'(aOv), 32'h0);
    checkOutput("pulse_end_busyA", 32'(aBusy), 32'h0);
    checkOutput("align_validB", 32'(bOv), 32'hF);
    checkOutput("align_dataB", bOd, 32'h44332211);
    applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);

    // Stream 1..8 on lane 2 with a 3-cycle stall before word 5.
    for (int w = 1; w <= 13; w++) begin
      if (w == 5) begin
        for (int s = 0; s < 3; s++) begin
          applyStimulus(4'h4, 32'h00EE0000, 3'h0, 24'h0, 1'b0, 1'b0);
        end
      end
      if (w <= 8) applyStimulus(4'h4, 32'(w) << 16, 3'h0, 24'h0, 1'b1, 1'b0);
      else        applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);
      if (aOv[2]) seen.push_back(aOd[23:16]);
    end
    checkOutput("stall_count", 32'(seen.size()), 32'd8);
    for (int k = 0; k < seen.size(); k++) begin
      checkOutput($sformatf("stall_word_%0d", k), 32'(seen[k]), 32'(k + 1));
    end

    // Fill, then flush together with en. The flush-cycle input must vanish.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'hF, $urandom, 3'h7, 24'($urandom), 1'b1, 1'b0);
    end
    applyStimulus(4'hF, 32'hDEADBEEF, 3'h7, 24'hBEEF01, 1'b1, 1'b1);
    checkOutput("flush_validA", 32'(aOv), 32'h0);
    checkOutput("flush_busyA", 32'(aBusy), 32'h0);
    checkOutput("flush_busyB", 32'(bBusy), 32'h0);
    checkOutput("flush_busyC", 32'(cBusy), 32'h0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);
      checkOutput($sformatf("flush_gone_%0d", k), 32'(aOv), 32'h0);
    end

    // Lane 0 of uC is combinational and ignores en.
    en = 1'b0; cIv = 3'b001; cId = 24'h00005A;
    #1;
    checkOutput("pass_valid", 32'(cOv[0]), 32'h1);
    checkOutput("pass_data", 32'(cOd[7:0]), 32'h5A);
    cIv = 3'b000;
    #1;
    checkOutput("pass_zero_valid", 32'(cOv[0]), 32'h0);
    checkOutput("pass_zero_data", 32'(cOd[7:0]), 32'h0);
    @(posedge clk); #2;
    applyStimulus(4'h0, 32'h0, 3'b010, 24'h007700, 1'b1, 1'b0);
    checkOutput("c_lane1_early", 32'(cOv[1]), 32'h0);
    applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);
    checkOutput("c_lane1_valid", 32'(cOv[1]), 32'h1);
    checkOutput("c_lane1_data", 32'(cOd[15:8]), 32'h77);

    // Asynchronous reset while words are in flight.
    applyStimulus(4'hF, 32'hA1B2C3D4, 3'h7, 24'h123456, 1'b1, 1'b0);
    applyStimulus(4'hF, 32'hA1B2C3D4, 3'h7, 24'h123456, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("arst_validA", 32'(aOv), 32'h0);
    checkOutput("arst_dataA", aOd, 32'h0);
    checkOutput("arst_busyA", 32'(aBusy), 32'h0);
    checkOutput("arst_validB", 32'(bOv), 32'h0);
    checkOutput("arst_busyB", 32'(bBusy), 32'h0);
    checkOutput("arst_busyC", 32'(cBusy), 32'h0);
    checkOutput("arst_validC", 32'(cOv[2:1]), 32'h0);
    applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);
    rst = 1'b0;
    applyStimulus(4'hF, 32'h55667788, 3'h0, 24'h0, 1'b1, 1'b0);
    checkOutput("post_rst_validA", 32'(aOv), 32'h1);
    checkOutput("post_rst_dataA", aOd, 32'h88);

    // Randomized traffic with random stalls, flushes and resets.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      applyStimulus(4'($urandom), $urandom, 3'($urandom), 24'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'h0, 32'h0, 3'h0, 24'h0, 1'b1, 1'b0);
    end
    checkOutput("drain_busyA", 32'(aBusy), 32'h0);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
